// File: rtl/window_collector_kxk.sv
// Streaming KxK window collector: K-1 line buffers feed a KxK shift window; one window per legal position.
// Optional WIN_COORD_EN adds out_row/out_col, the image coordinate of window element (0,0).
module window_collector_kxk #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_pixel,
  input  logic                    in_sof,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*K*DATA_W-1:0]   out_window,
`ifdef WIN_COORD_EN
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
`endif
  output logic                    frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic K1_ODD = 1'((K - 1) % 2);

  logic [RW-1:0]     row, cur_row;
  logic [CW-1:0]     col, cur_col;
  logic              accept, emit, last_px, row_phase_ok, col_phase_ok;
  logic [DATA_W-1:0] line_buf [K-1][IMG_W];
  logic [DATA_W-1:0] win      [K][K];
  logic [DATA_W-1:0] new_col  [K];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is (0,0) whatever the counters say.
  always_comb begin
    cur_row      = in_sof ? '0 : row;
    cur_col      = in_sof ? '0 : col;
    row_phase_ok = (STRIDE == 1) || (cur_row[0] == K1_ODD);
    col_phase_ok = (STRIDE == 1) || (cur_col[0] == K1_ODD);
    emit         = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1)) &&
                   row_phase_ok && col_phase_ok;
    last_px      = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
  end

  always_comb begin
    for (int i = 0; i < K; i++) new_col[i] = '0;
    for (int i = 0; i < K - 1; i++) new_col[i] = line_buf[i][cur_col];
    new_col[K-1] = in_pixel;
  end

  // line_buf[0] holds the oldest line; each column shifts up by one line per accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 2; i++) line_buf[i][cur_col] <= line_buf[i+1][cur_col];
      line_buf[K-2][cur_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= new_col[r];
      end
    end
  end

  always_comb begin
    out_window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        out_window[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
  end

  // A new window load takes priority over clearing on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef WIN_COORD_EN
      out_row    <= '0;
      out_col    <= '0;
`endif
    end else begin
      frame_done <= accept && last_px;
      if (accept) begin
        if (cur_col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= last_px ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
`ifdef WIN_COORD_EN
        out_row   <= cur_row - RW'(K - 1);
        out_col   <= cur_col - CW'(K - 1);
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_collector_kxk.sv
// Bench for window_collector_kxk: three instances (K3/S1, K3/S2, K5/S1) on an 8x6 image checked against a frame model.
module tb_window_collector_kxk;

  localparam int WMAX = 200;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_sof, out_ready;
  logic [7:0] in_pixel;
  logic in_valid_aux;

  logic ir0, ir1, ir2, ov0, ov1, ov2, fd0, fd1, fd2;
  logic [71:0]  w0, w1;
  logic [199:0] w2;
`ifdef WIN_COORD_EN
  logic [2:0] orow0, ocol0, orow1, ocol1, orow2, ocol2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Auxiliaries see exactly the pixels the main instance accepts.
  assign in_valid_aux = in_valid && ir0;

  window_collector_kxk #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .K(3), .STRIDE(1)) dut_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(ov0), .out_ready(out_ready), .out_window(w0),
`ifdef WIN_COORD_EN
    .out_row(orow0), .out_col(ocol0),
`endif
    .frame_done(fd0));

  window_collector_kxk #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .K(3), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_aux), .in_ready(ir1), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(ov1), .out_ready(1'b1), .out_window(w1),
`ifdef WIN_COORD_EN
    .out_row(orow1), .out_col(ocol1),
`endif
    .frame_done(fd1));

  window_collector_kxk #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .K(5), .STRIDE(1)) dut_k5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_aux), .in_ready(ir2), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(ov2), .out_ready(1'b1), .out_window(w2),
`ifdef WIN_COORD_EN
    .out_row(orow2), .out_col(ocol2),
`endif
    .frame_done(fd2));

  task automatic chk(input string nm, input logic [WMAX-1:0] act, input logic [WMAX-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int p);
    return 8'((p / 8) * 16 + (p % 8));
  endfunction

  // ---------------- frame model ----------------
  int kk [3] = '{3, 3, 5};
  int ss [3] = '{1, 2, 1};
  logic [7:0] img [3][6][8];
  int mr [3], mc [3], er [3], ec [3];
  bit ev [3], efd [3];
  logic [WMAX-1:0] ew [3];
  int fd_cnt [3];
  logic [WMAX-1:0] log0[$], log1[$], log2[$], ref_log[$];
  logic [5:0] crd_log[$];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mr[d] = 0; mc[d] = 0; er[d] = 0; ec[d] = 0;
      ev[d] = 0; efd[d] = 0; ew[d] = '0;
    end
  endtask

  // Predicts the state after the coming rising edge from the inputs held stable now.
  task automatic model_step(input int d, input bit acc, input bit ordy);
    int k, s;
    k = kk[d]; s = ss[d];
    efd[d] = 0;
    if (ev[d] && ordy) ev[d] = 0;
    if (acc) begin
      if (in_sof) begin mr[d] = 0; mc[d] = 0; end
      img[d][mr[d]][mc[d]] = in_pixel;
      if (mr[d] >= k-1 && mc[d] >= k-1 && (mr[d]-k+1) % s == 0 && (mc[d]-k+1) % s == 0) begin
        ev[d] = 1;
        ew[d] = '0;
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            ew[d][(r*k+c)*8 +: 8] = img[d][mr[d]-k+1+r][mc[d]-k+1+c];
        er[d] = mr[d] - k + 1;
        ec[d] = mc[d] - k + 1;
      end
      if (mr[d] == 5 && mc[d] == 7) efd[d] = 1;
      mc[d]++;
      if (mc[d] == 8) begin
        mc[d] = 0;
        mr[d]++;
        if (mr[d] == 6) mr[d] = 0;
      end
    end
  endtask

  initial begin
    bit ovd [3], fdd [3], ord [3], accd [3];
    logic [WMAX-1:0] owd [3];
    model_reset();
    for (int d = 0; d < 3; d++) fd_cnt[d] = 0;
    forever begin
      @(negedge clk);
      ovd = '{ov0, ov1, ov2};
      fdd = '{fd0, fd1, fd2};
      owd = '{{128'b0, w0}, {128'b0, w1}, w2};
      ord = '{out_ready, 1'b1, 1'b1};
      accd = '{in_valid && ir0, in_valid_aux && ir1, in_valid_aux && ir2};
      if (!rst_n) model_reset();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("out_valid[%0d]", d), WMAX'(ovd[d]), WMAX'(ev[d]));
        chk($sformatf("frame_done[%0d]", d), WMAX'(fdd[d]), WMAX'(efd[d]));
        if (ev[d]) chk($sformatf("window[%0d]", d), owd[d], ew[d]);
        if (ovd[d] && ord[d]) begin
          if (d == 0) log0.push_back(owd[d]);
          else if (d == 1) log1.push_back(owd[d]);
          else log2.push_back(owd[d]);
        end
        if (fdd[d]) fd_cnt[d]++;
      end
`ifdef WIN_COORD_EN
      if (ev[0]) chk("coord0", WMAX'({orow0, ocol0}), WMAX'({3'(er[0]), 3'(ec[0])}));
      if (ev[1]) chk("coord1", WMAX'({orow1, ocol1}), WMAX'({3'(er[1]), 3'(ec[1])}));
      if (ev[2]) chk("coord2", WMAX'({orow2, ocol2}), WMAX'({3'(er[2]), 3'(ec[2])}));
      if (ov0 && out_ready) crd_log.push_back({orow0, ocol0});
`endif
      chk("in_ready_main", WMAX'(ir0), WMAX'(!ev[0] || out_ready));
      chk("in_ready_aux", WMAX'(ir1 && ir2), WMAX'(1));
      if (rst_n) for (int d = 0; d < 3; d++) model_step(d, accd[d], ord[d]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_logs();
    log0.delete(); log1.delete(); log2.delete(); crd_log.delete();
    for (int d = 0; d < 3; d++) fd_cnt[d] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input int n_pix, input int idle_pct, input bit bp);
    int p, cyc, bp_cnt;
    logic [WMAX-1:0] held;
    p = 0; cyc = 0; bp_cnt = 0; held = '0;
    if (bp) out_ready = 1'b0;
    while (p < n_pix && cyc < 1000) begin
      if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
        in_valid = 1'b0; in_sof = 1'b0;
      end else begin
        in_valid = 1'b1; in_pixel = pix(p); in_sof = (p == 0);
      end
      @(negedge clk);
      if (bp && bp_cnt < 5 && ov0) begin
        if (bp_cnt == 0) held = {128'b0, w0};
        chk("bp_in_ready", WMAX'(ir0), WMAX'(0));
        chk("bp_hold", {128'b0, w0}, held);
        bp_cnt++;
      end
      if (in_valid && ir0) p++;
      @(posedge clk); #1;
      if (bp && bp_cnt >= 5) out_ready = 1'b1;
      cyc++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    chk("pixels_sent", WMAX'(p), WMAX'(n_pix));
    if (bp) chk("bp_cycles", WMAX'(bp_cnt), WMAX'(5));
    out_ready = 1'b1;
  endtask

  task automatic cmp_ref(input string nm);
    chk({nm, "_count"}, WMAX'(log0.size()), WMAX'(24));
    for (int i = 0; i < log0.size() && i < ref_log.size(); i++)
      chk($sformatf("%s_win%0d", nm, i), log0[i], ref_log[i]);
  endtask

  initial begin
    logic [7:0] s2_tl [6];
    s2_tl = '{8'h00, 8'h02, 8'h04, 8'h20, 8'h22, 8'h24};
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
    #1;
    idle(2);
    chk("rst_out_valid", WMAX'(ov0), WMAX'(0));
    chk("rst_in_ready", WMAX'(ir0), WMAX'(1));
    chk("rst_frame_done", WMAX'(fd0), WMAX'(0));
    chk("rst_window", WMAX'(w0), WMAX'(0));
    rst_n = 1'b1;
    idle(2);

    // continuous frame
    clear_logs();
    run_frame(48, 0, 1'b0);
    idle(3);
    chk("k3s1_count", WMAX'(log0.size()), WMAX'(24));
    if (log0.size() == 24) begin
      chk("k3s1_first_00", WMAX'(log0[0][7:0]), WMAX'(8'h00));
      chk("k3s1_first_22", WMAX'(log0[0][71:64]), WMAX'(8'h22));
      chk("k3s1_last_22", WMAX'(log0[23][71:64]), WMAX'(8'h57));
    end
    chk("k3s1_frame_done", WMAX'(fd_cnt[0]), WMAX'(1));
    chk("k3s2_count", WMAX'(log1.size()), WMAX'(6));
    for (int i = 0; i < log1.size() && i < 6; i++)
      chk($sformatf("k3s2_tl%0d", i), WMAX'(log1[i][7:0]), WMAX'(s2_tl[i]));
    chk("k5_count", WMAX'(log2.size()), WMAX'(8));
    if (log2.size() > 0) begin
      chk("k5_first_00", WMAX'(log2[0][7:0]), WMAX'(8'h00));
      chk("k5_first_44", WMAX'(log2[0][199:192]), WMAX'(8'h44));
    end
    ref_log = log0;

    // backpressure after first window
    clear_logs();
    run_frame(48, 0, 1'b1);
    idle(3);
    cmp_ref("bp");

    // 30% idle input gaps
    clear_logs();
    run_frame(48, 30, 1'b0);
    idle(3);
    cmp_ref("gaps");

    // start-of-frame at pixel 10 of a frame
    clear_logs();
    run_frame(10, 0, 1'b0);
    run_frame(48, 0, 1'b0);
    idle(3);
    cmp_ref("resync");
    chk("resync_frame_done", WMAX'(fd_cnt[0]), WMAX'(1));

    // reset mid-frame with a window pending
    run_frame(20, 0, 1'b0);
    chk("pre_rst_valid", WMAX'(ov0), WMAX'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", WMAX'(ov0), WMAX'(0));
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_logs();
    run_frame(48, 0, 1'b0);
    idle(3);
    cmp_ref("post_rst");
`ifdef WIN_COORD_EN
    if (crd_log.size() > 0) chk("first_coord", WMAX'(crd_log[0]), WMAX'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_collector_kxk.md
Name: window_collector_kxk

Overview:
- Parametrised successor of the 3x3 window collector in the accelerator streaming front end.
- Accepts a raster-order pixel stream with valid/ready handshake and buffers K-1 image lines internally.
- Emits one KxK window per legal output position, with configurable stride and downstream backpressure.
- Feeds the convolution engines; replaces free-running stall-based collection with explicit valid/ready flow control.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 256, pixels per line (>= K)
IMG_H, 256, lines per frame (>= K)
K, 3, kernel size; legal values 3, 5, 7
STRIDE, 1, output stride in both axes; legal values 1, 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel present on in_pixel
in_ready  output  1  block can accept a pixel this cycle
in_pixel  input  DATA_W  pixel data, raster order
in_sof  input  1  start of frame; qualified by in_valid && in_ready
out_valid  output  1  out_window holds a valid window
out_ready  input  1  downstream accepts the window
out_window  output  K*K*DATA_W  window; element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; r=0 is the oldest line, c=0 is the leftmost column
frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Handshake and flow control:
  - Pixel accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Window transfers when out_valid && out_ready.
  - out_window holds stable while out_valid && !out_ready.
- Storage:
  - K-1 line buffers of IMG_W x DATA_W.
  - KxK register window.
  - All shift on accept only; nothing moves when no pixel is accepted.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) describe the accepted pixel.
  - col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done pulses on the next cycle.
- in_sof accepted: that pixel is treated as (0,0) regardless of counter state.
  - Line buffer contents are not cleared.
  - Windows are suppressed until K-1 new lines have been received.
- Window emit condition, evaluated on the accepted pixel: row >= K-1, col >= K-1, (row-(K-1)) % STRIDE == 0, and (col-(K-1)) % STRIDE == 0.
  - The accepted pixel becomes element (K-1,K-1).
- Latency: out_valid is registered and asserts 1 cycle after the accept of the completing pixel.
  - out_valid clears after a transfer unless a new window is loaded in the same cycle.
  - Back-to-back windows are allowed at 1 window/cycle.
- Window columns never straddle a line boundary: columns 0..K-2 of a new line only refill the shift window.
- Windows per frame: ((IMG_H-K)/STRIDE+1) * ((IMG_W-K)/STRIDE+1), integer division.
- Reset (async assert, sync-safe deassert):
  - row=0, col=0, out_valid=0, out_window=0, frame_done=0.
  - in_ready=1 after reset.
  - Line buffer RAM is not reset.
  - Reset mid-frame discards partial state; the next accepted pixel is (0,0).
- Simultaneous events:
  - A window transfer and a new window load in the same cycle: the new window wins and out_valid stays 1.
  - in_sof on the last pixel of a frame: in_sof takes priority and no frame_done is generated.

Optional Feature:
WIN_COORD_EN:
- Defined: adds output ports out_row [$clog2(IMG_H)-1:0] and out_col [$clog2(IMG_W)-1:0], giving the image coordinate of element (0,0) of the current window.
  - Registered alongside out_window, held under backpressure, reset to 0.
- Undefined: ports absent; no coordinate registers are synthesised.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, DATA_W=8 and pixel = row*16+col.
- Basic K=3, STRIDE=1, continuous valid, out_ready=1:
  - Exactly 24 windows.
  - First window one cycle after accepting pixel 0x22, with element (0,0)=0x00 and (2,2)=0x22.
  - Last window has (2,2)=0x57.
  - frame_done pulses once.
- K=3, STRIDE=2:
  - Exactly 6 windows.
  - Top-left elements are 0x00, 0x02, 0x04, 0x20, 0x22, 0x24.
- K=5, STRIDE=1:
  - Exactly 8 windows.
  - First window (0,0)=0x00 and (4,4)=0x44.
- Backpressure: hold out_ready=0 for 5 cycles after the first window.
  - in_ready=0 throughout; out_window is unchanged.
  - Release: the window transfers and no pixel or window is lost; the total is still 24.
- Random in_valid gaps with 30% idle:
  - The window sequence is identical to the continuous case.
- Resync and reset:
  - Assert in_sof at pixel 10 of a frame: no window until row 2 of the new frame.
  - rst_n low mid-frame: out_valid=0 immediately.
  - Then a full frame yields 24 correct windows.
  - With WIN_COORD_EN, the first window reports out_row=0, out_col=0.
